// File: rtl/cic_switchless_ctrl.sv
// Purpose : host-side CIC controller with button debounce, console reset sequencing and a switchless NTSC/PAL toggle on long press.
// Latency : button edge to FSM reaction 2 + DEBOUNCE_CYCLES cycles; led_err 1 cycle; cic_seed combinational from region_pal.
// Backpr. : none (free-running control; the button is ignored while the CIC is held in reset).
//
// Ports:
//   clk           CIC clock
//   rst           asynchronous active-low reset
//   btn_n         raw front-panel reset button, active-low, asynchronous and bouncy
//   cic_rst_host  CIC request to hold the console in reset
//   cic_dead      CIC authentication failure flag
//   cic_rst       reset to the CIC core, active-high
//   cic_seed      region/seed select to the CIC core
//   console_rst_n console reset, active-low
//   region_pal    region select to video/PPU (1 = PAL)
//   led_err       error LED
module cic_switchless_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16384,
  parameter int unsigned LONG_PRESS_CYCLES = 4000000,
  parameter int unsigned CIC_RST_CYCLES    = 256,
  parameter logic        DEFAULT_REGION    = 1'b0,
  parameter int unsigned CNT_W             = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic cic_rst_host,
  input  logic cic_dead,
  output logic cic_rst,
  output logic cic_seed,
  output logic console_rst_n,
  output logic region_pal,
  output logic led_err
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(CIC_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    PRESSED,
    LONG,
    CIC_RESET
  } state_t;

  state_t            state;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_db_n;
  logic [CNT_W-1:0]  db_cnt;
  logic [CNT_W-1:0]  rst_cnt;
  logic [CNT_W-1:0]  press_cnt;

  logic              db_fire;
  logic              btn_db_n_nxt;
  logic              pressed;
  logic              run_con_n;

  // The FSM looks at the debounced level as it will be after this edge, so the
  // state change lands on the same edge as the debounced level change.
  assign db_fire      = (btn_s2 != btn_db_n) && (db_cnt == DB_LAST);
  assign btn_db_n_nxt = db_fire ? btn_s2 : btn_db_n;
  assign pressed      = ~btn_db_n_nxt;
  assign run_con_n    = ~(cic_rst_host | cic_dead);

  assign cic_seed = region_pal;

  // Synchronizer and debouncer: the debounced level only moves after the
  // synced level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1   <= 1'b1;
      btn_s2   <= 1'b1;
      btn_db_n <= 1'b1;
      db_cnt   <= '0;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_db_n) begin
        db_cnt <= '0;
      end else if (db_fire) begin
        btn_db_n <= btn_s2;
        db_cnt   <= '0;
      end else if (db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_err <= 1'b0;
    end else begin
      led_err <= cic_dead;
    end
  end

  // Main sequencer; outputs are registered with the values of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= BOOT;
      cic_rst       <= 1'b1;
      console_rst_n <= 1'b0;
      region_pal    <= DEFAULT_REGION;
      rst_cnt       <= '0;
      press_cnt     <= '0;
    end else begin
      case (state)
        BOOT, CIC_RESET: begin
          // Button is ignored while the CIC is held in reset.
          if (rst_cnt == RST_LAST) begin
            state         <= RUN;
            rst_cnt       <= '0;
            cic_rst       <= 1'b0;
            console_rst_n <= run_con_n;
          end else begin
            cic_rst       <= 1'b1;
            console_rst_n <= 1'b0;
            if (rst_cnt != CNT_MAX) rst_cnt <= rst_cnt + CNT_ONE;
          end
        end

        RUN: begin
          cic_rst <= 1'b0;
          // Level-sensitive: a press still held when RUN is re-entered counts again.
          if (pressed) begin
            state         <= PRESSED;
            press_cnt     <= '0;
            console_rst_n <= 1'b0;
          end else begin
            console_rst_n <= run_con_n;
          end
        end

        PRESSED: begin
          console_rst_n <= 1'b0;
          // Threshold is checked before release so a release on the threshold
          // cycle still counts as a long press.
          if (press_cnt == LONG_LAST) begin
            region_pal <= ~region_pal;
            state      <= LONG;
            cic_rst    <= 1'b1;
          end else if (!pressed) begin
            state   <= CIC_RESET;
            rst_cnt <= '0;
            cic_rst <= 1'b1;
          end else begin
            cic_rst <= 1'b0;
            if (press_cnt != CNT_MAX) press_cnt <= press_cnt + CNT_ONE;
          end
        end

        LONG: begin
          // Region is held here; no further toggles while the button stays down.
          cic_rst       <= 1'b1;
          console_rst_n <= 1'b0;
          if (!pressed) begin
            state   <= CIC_RESET;
            rst_cnt <= '0;
          end
        end

        default: begin
          state         <= BOOT;
          cic_rst       <= 1'b1;
          console_rst_n <= 1'b0;
          rst_cnt       <= '0;
          press_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cic_switchless_ctrl.sv
// Purpose : directed self-checking bench for cic_switchless_ctrl with small timing parameters.
// Latency : outputs sampled 1 time unit after each falling clock edge.
// Backpr. : none.
module tb_cic_switchless_ctrl;

  logic clk;
  logic rst;
  logic btn_n;
  logic cic_rst_host;
  logic cic_dead;
  logic cic_rst;
  logic cic_seed;
  logic console_rst_n;
  logic region_pal;
  logic led_err;

  int checks = 0;
  int errors = 0;

  cic_switchless_ctrl #(
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .CIC_RST_CYCLES    (8),
    .DEFAULT_REGION    (1'b0),
    .CNT_W             (23)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_n         (btn_n),
    .cic_rst_host  (cic_rst_host),
    .cic_dead      (cic_dead),
    .cic_rst       (cic_rst),
    .cic_seed      (cic_seed),
    .console_rst_n (console_rst_n),
    .region_pal    (region_pal),
    .led_err       (led_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst_v;
    logic btn;
    logic host;
    logic dead;
    int   n;
    logic e_cic;
    logic e_con;
    logic e_reg;
    logic e_led;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic b, input logic h, input logic d, input int n,
                     input logic c, input logic o, input logic g, input logic l);
    vec_t v;
    v.rst_v = r; v.btn = b; v.host = h; v.dead = d; v.n = n;
    v.e_cic = c; v.e_con = o; v.e_reg = g; v.e_led = l;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_cic, input logic e_con,
                         input logic e_reg, input logic e_led);
    chk({tag, " cic_rst"},       cic_rst,       e_cic);
    chk({tag, " console_rst_n"}, console_rst_n, e_con);
    chk({tag, " region_pal"},    region_pal,    e_reg);
    chk({tag, " cic_seed"},      cic_seed,      e_reg);
    chk({tag, " led_err"},       led_err,       e_led);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; btn_n = 1'b1; cic_rst_host = 1'b0; cic_dead = 1'b0;

    //   rst btn host dead  n   cic con reg led
    // reset and boot
    add(0, 1, 0, 0,  2,  1, 0, 0, 0);
    add(1, 1, 0, 0,  7,  1, 0, 0, 0);
    add(1, 1, 0, 0,  1,  0, 1, 0, 0);
    add(1, 1, 1, 0,  1,  0, 0, 0, 0);
    add(1, 1, 0, 0,  1,  0, 1, 0, 0);
    // short press, 10 cycles
    add(1, 0, 0, 0,  5,  0, 1, 0, 0);
    add(1, 0, 0, 0,  1,  0, 0, 0, 0);
    add(1, 0, 0, 0,  4,  0, 0, 0, 0);
    add(1, 1, 0, 0,  5,  0, 0, 0, 0);
    add(1, 1, 0, 0,  1,  1, 0, 0, 0);
    add(1, 1, 0, 0,  7,  1, 0, 0, 0);
    add(1, 1, 0, 0,  1,  0, 1, 0, 0);
    // glitch one cycle shorter than the debounce window
    add(1, 0, 0, 0,  3,  0, 1, 0, 0);
    add(1, 1, 0, 0,  8,  0, 1, 0, 0);
    // press exactly as long as the debounce window
    add(1, 0, 0, 0,  4,  0, 1, 0, 0);
    add(1, 1, 0, 0,  2,  0, 0, 0, 0);
    add(1, 1, 0, 0,  4,  1, 0, 0, 0);
    add(1, 1, 0, 0,  8,  0, 1, 0, 0);
    // authentication failure
    add(1, 1, 0, 1,  1,  0, 0, 0, 1);
    add(1, 1, 0, 0,  1,  0, 1, 0, 0);
    // long press, 60 cycles
    add(1, 0, 0, 0,  6,  0, 0, 0, 0);
    add(1, 0, 0, 0, 19,  0, 0, 0, 0);
    add(1, 0, 0, 0,  1,  1, 0, 1, 0);
    add(1, 0, 0, 0, 34,  1, 0, 1, 0);
    add(1, 1, 0, 0,  5,  1, 0, 1, 0);
    add(1, 1, 0, 0,  1,  1, 0, 1, 0);
    add(1, 1, 0, 0,  7,  1, 0, 1, 0);
    add(1, 1, 0, 0,  1,  0, 1, 1, 0);
    // release lands on the long-press threshold cycle
    add(1, 0, 0, 0, 20,  0, 0, 1, 0);
    add(1, 1, 0, 0,  6,  1, 0, 0, 0);
    add(1, 1, 0, 0,  8,  1, 0, 0, 0);
    add(1, 1, 0, 0,  1,  0, 1, 0, 0);

    foreach (vq[i]) begin
      rst          = vq[i].rst_v;
      btn_n        = vq[i].btn;
      cic_rst_host = vq[i].host;
      cic_dead     = vq[i].dead;
      step(vq[i].n);
      chk_out($sformatf("vec%0d", i), vq[i].e_cic, vq[i].e_con, vq[i].e_reg, vq[i].e_led);
    end

    // Bounce: toggle every 2 cycles for 40 cycles, ending high.
    for (int i = 0; i < 20; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(2);
      chk($sformatf("bounce%0d cic_rst", i), cic_rst, 1'b0);
      chk($sformatf("bounce%0d console_rst_n", i), console_rst_n, 1'b1);
    end
    step(8);
    chk_out("bounce_end", 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in LONG after a toggle.
    btn_n = 1'b0;
    step(26);
    chk_out("pre_rst_long", 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    btn_n = 1'b1;
    step(1);
    rst = 1'b1;
    step(7);
    chk_out("reboot_boot", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_out("reboot_run", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
